// File: rtl/execute_cycle.sv
// execute_cycle -- EX stage of a 5-stage RISC-V style pipeline plus the
// EX/MEM pipeline register.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   RegWriteE, MemWriteE,
//   BranchE, ALUSrcE            decoded controls from the decode stage
//   ResultSrcE[1:0]             writeback source select (00 ALU, 01 mem, 10 PC+4)
//   ALUControlE[2:0]            ALU operation select
//   RD1_E, RD2_E, Imm_Ext_E,
//   PCE, PCPlus4E [31:0]        operands, immediate and PC values
//   RD_E[4:0]                   destination register
//   ForwardA_E, ForwardB_E[1:0] forwarding selects from the hazard unit
//   ResultW[31:0]               writeback-stage result (forward source 01)
//   StallM                      holds the EX/MEM register
//   PCSrcE, PCTargetE           branch redirect and target (combinational)
//   RegWriteM, MemWriteM,
//   ResultSrcM, RD_M,
//   ALUResultM, WriteDataM,
//   PCPlus4M                    registered EX/MEM outputs
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    input  logic        StallM,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero_e;

    // Forward select 10 takes the current (pre-edge) ALUResultM, which is the
    // result of the instruction directly ahead of this one.
    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    always_comb begin
        case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero_e    = (alu_result == '0);
    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Reset wins over stall; store data is the forwarded B value, not SrcB.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (!StallM) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [31:0] ResultW;
    logic        StallM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
        .StallM(StallM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } regs_t;

    regs_t exp_q[$];
    regs_t model;
    regs_t got;
    regs_t e;
    int    checks = 0;
    int    errors = 0;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return model.alu;
        return rf;
    endfunction

    // Expected EX/MEM contents after the next edge, from the current inputs.
    function automatic regs_t predict();
        regs_t r;
        logic [31:0] a, fb, b;
        if (rst) return '0;
        if (StallM) return model;
        a  = ref_fwd(ForwardA_E, RD1_E);
        fb = ref_fwd(ForwardB_E, RD2_E);
        b  = ALUSrcE ? Imm_Ext_E : fb;
        r.rw = RegWriteE; r.mw = MemWriteE; r.rs = ResultSrcE; r.rd = RD_E;
        r.alu = ref_alu(ALUControlE, a, b); r.wd = fb; r.pc4 = PCPlus4E;
        return r;
    endfunction

    function automatic regs_t dut_regs();
        return {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
    endfunction

    // Push the expectation for the inputs now applied and advance the model.
    task automatic issue();
        model = predict();
        exp_q.push_back(model);
    endtask

    task automatic idle_inputs();
        rst = 0; StallM = 0;
        RegWriteE = 0; MemWriteE = 0; BranchE = 0; ALUSrcE = 0;
        ResultSrcE = 0; ALUControlE = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
        RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst = 1; StallM = 1'($urandom_range(1));
            RegWriteE = 1'($urandom_range(1)); MemWriteE = 1'($urandom_range(1));
            BranchE = 1'($urandom_range(1)); ALUSrcE = 1'($urandom_range(1));
            ResultSrcE = 2'($urandom_range(3)); ALUControlE = 3'($urandom_range(7));
            RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; PCE = $urandom;
            PCPlus4E = $urandom; RD_E = 5'($urandom_range(31));
            ForwardA_E = 2'($urandom_range(3)); ForwardB_E = 2'($urandom_range(3));
            ResultW = $urandom;
            #1;
            checks++;
            if (PCTargetE !== PCE + Imm_Ext_E) begin
                errors++;
                $display("FAIL reset_pctarget: got %h expected %h", PCTargetE, PCE + Imm_Ext_E);
            end
            issue();
            @(posedge clk); #1;
            got = dut_regs(); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_regs: got %h expected %h", got, e);
            end
        end
        idle_inputs();
    endtask

    task automatic test_add_imm();
        idle_inputs();
        RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; RD_E = 3; RegWriteE = 1;
        RD2_E = 32'h99; PCPlus4E = 32'h1004;
        issue();
        @(posedge clk); #1;
        got = dut_regs(); e = exp_q.pop_front();
        checks++;
        if (got !== e || ALUResultM !== 32'd12 || RD_M !== 5'd3 || RegWriteM !== 1'b1) begin
            errors++;
            $display("FAIL add_imm: got %h expected %h (alu 12 rd 3 rw 1)", got, e);
        end
    endtask

    task automatic test_forwarding();
        // {fwdA, fwdB, alu op, RD1, RD2, ResultW, expected ALUResultM}
        logic [1:0]  fa [5] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
        logic [1:0]  fb [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [2:0]  op [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
        logic [31:0] r1 [5] = '{32'h10, 32'h0, 32'h0, 32'h7, 32'h1};
        logic [31:0] r2 [5] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h50};
        logic [31:0] rw [5] = '{32'h0, 32'h0, 32'h9, 32'h9, 32'h0};
        logic [31:0] ex [5] = '{32'h10, 32'hC, 32'h5, 32'h3, 32'h4};
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            ForwardA_E = fa[i]; ForwardB_E = fb[i]; ALUControlE = op[i];
            RD1_E = r1[i]; RD2_E = r2[i]; ResultW = rw[i]; RD_E = 5'(i + 1);
            issue();
            @(posedge clk); #1;
            got = dut_regs(); e = exp_q.pop_front();
            checks++;
            if (got !== e || ALUResultM !== ex[i]) begin
                errors++;
                $display("FAIL forward_%0d: got %h expected %h (alu %h)", i, got, e, ex[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] r2 [3] = '{32'h20, 32'h21, 32'h20};
        logic        br [3] = '{1'b1, 1'b1, 1'b0};
        logic        tk [3] = '{1'b1, 1'b0, 1'b0};
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            BranchE = br[i]; RD1_E = 32'h20; RD2_E = r2[i]; ALUControlE = 3'd1;
            PCE = 32'h100; Imm_Ext_E = 32'h40;
            #1;
            checks++;
            if (PCSrcE !== tk[i] || PCTargetE !== 32'h140) begin
                errors++;
                $display("FAIL branch_%0d: got pcsrc %b target %h expected %b 140", i, PCSrcE, PCTargetE, tk[i]);
            end
            issue();
            @(posedge clk); #1;
            got = dut_regs(); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL branch_regs_%0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_alu_ops();
        // slt signed both directions, and/or, and unused codes yielding 0
        logic [2:0]  op [7] = '{3'd5, 3'd5, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        logic [31:0] r1 [7] = '{32'hFFFFFFFF, 32'h1, 32'hF0F0, 32'hF0F0, 32'h3, 32'h3, 32'h3};
        logic [31:0] r2 [7] = '{32'h1, 32'hFFFFFFFF, 32'hFF00, 32'hFF00, 32'h5, 32'h5, 32'h5};
        logic [31:0] ex [7] = '{32'h1, 32'h0, 32'hF000, 32'hFFF0, 32'h0, 32'h0, 32'h0};
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            ALUControlE = op[i]; RD1_E = r1[i]; RD2_E = r2[i];
            issue();
            @(posedge clk); #1;
            got = dut_regs(); e = exp_q.pop_front();
            checks++;
            if (got !== e || ALUResultM !== ex[i]) begin
                errors++;
                $display("FAIL alu_%0d: got %h expected %h (alu %h)", i, got, e, ex[i]);
            end
        end
    endtask

    task automatic test_store();
        idle_inputs();
        MemWriteE = 1; ALUSrcE = 1; ForwardB_E = 2'b01; ResultW = 32'hAB;
        RD1_E = 32'h100; RD2_E = 32'h55; Imm_Ext_E = 32'h8; PCPlus4E = 32'h2008;
        issue();
        @(posedge clk); #1;
        got = dut_regs(); e = exp_q.pop_front();
        checks++;
        if (got !== e || WriteDataM !== 32'hAB || ALUResultM !== 32'h108 || MemWriteM !== 1'b1) begin
            errors++;
            $display("FAIL store: got %h expected %h (wd AB alu 108)", got, e);
        end
    endtask

    task automatic test_stall_reset();
        idle_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; RD_E = 5'd17;
        RD1_E = 32'h1234; RD2_E = 32'h11; PCPlus4E = 32'h3004;
        issue();
        @(posedge clk); #1;
        got = dut_regs(); e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL stall_setup: got %h expected %h", got, e);
        end
        for (int i = 0; i < 3; i++) begin
            StallM = 1;
            RegWriteE = 1'($urandom_range(1)); MemWriteE = 1'($urandom_range(1));
            ALUControlE = 3'($urandom_range(7)); RD1_E = $urandom; RD2_E = $urandom;
            RD_E = 5'($urandom_range(31)); PCPlus4E = $urandom;
            PCE = $urandom; Imm_Ext_E = $urandom;
            #1;
            checks++;
            if (PCTargetE !== PCE + Imm_Ext_E) begin
                errors++;
                $display("FAIL stall_pctarget_%0d: got %h expected %h", i, PCTargetE, PCE + Imm_Ext_E);
            end
            issue();
            @(posedge clk); #1;
            got = dut_regs(); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, got, e);
            end
        end
        rst = 1; StallM = 1;
        issue();
        @(posedge clk); #1;
        got = dut_regs(); e = exp_q.pop_front();
        checks++;
        if (got !== e || got !== '0) begin
            errors++;
            $display("FAIL reset_over_stall: got %h expected %h", got, e);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        // chained accumulation through forward select 10 every cycle
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            ForwardA_E = (i == 0) ? 2'b00 : 2'b10;
            RD1_E = 32'hDEAD0000; RD2_E = 32'(i * 3 + 1); ALUControlE = 3'd0;
            RegWriteE = 1; RD_E = 5'd9;
            issue();
            @(posedge clk); #1;
            got = dut_regs(); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    initial begin
        idle_inputs();
        model = '0;
        test_reset();
        test_add_imm();
        test_forwarding();
        test_branch();
        test_alu_ops();
        test_store();
        test_stall_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset, and SHALL have no parameters.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 RegWriteE, MemWriteE, BranchE, ALUSrcE  in  1 each  decoded controls from the decode stage.
REQ-005 ResultSrcE  in  2  writeback source select: 00 ALU, 01 memory, 10 PC+4.
REQ-006 ALUControlE  in  3  ALU operation select.
REQ-007 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands, immediate and PC values.
REQ-008 RD_E  in  5  destination register.
REQ-009 ForwardA_E, ForwardB_E  in  2 each  forwarding select from the hazard unit.
REQ-010 ResultW  in  32  writeback-stage result.
REQ-011 StallM  in  1  holds the EX/MEM register.
REQ-012 PCSrcE  out  1  branch-taken redirect, combinational.
REQ-013 PCTargetE  out  32  branch target, combinational.
REQ-014 RegWriteM, MemWriteM  out  1 each  registered controls.
REQ-015 ResultSrcM  out  2  registered writeback source select.
REQ-016 RD_M  out  5  registered destination register.
REQ-017 ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered data.

Function
REQ-018 SrcA SHALL be selected by ForwardA_E: 00 -> RD1_E, 01 -> ResultW, 10 -> ALUResultM; 11 -> RD1_E.
REQ-019 The forwarded B value SHALL be selected by ForwardB_E using the same encoding as REQ-018, with RD2_E in place of RD1_E.
REQ-020 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, otherwise the forwarded B value.
REQ-021 The ALU SHALL compute: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 0 or 1); every other code SHALL produce 0.
REQ-022 Add and sub SHALL be 32-bit modulo, with no overflow flag.
REQ-023 ZeroE SHALL be 1 iff the ALU result equals 0.
REQ-024 PCSrcE SHALL equal BranchE & ZeroE.
REQ-025 PCTargetE SHALL equal PCE + Imm_Ext_E, modulo 2^32.
REQ-026 On each rising edge with rst=0 and StallM=0, the EX/MEM register SHALL capture the following, giving a latency of 1 cycle:
- RegWriteE, MemWriteE, ResultSrcE and RD_E;
- the ALU result into ALUResultM;
- the forwarded B value (not SrcB) into WriteDataM;
- PCPlus4E into PCPlus4M.
REQ-027 With StallM=1 and rst=0, all registered outputs SHALL hold their values.
REQ-028 Combinational outputs SHALL keep following the current inputs during a stall.
REQ-029 Forward select 10 SHALL use the pre-edge ALUResultM, which gives back-to-back dependency forwarding.

Reset
REQ-030 On a rising edge with rst=1, all registered outputs SHALL become 0, regardless of StallM.
REQ-031 Reset mid-stream SHALL discard the in-flight instruction, leaving no residual RegWriteM or MemWriteM.
REQ-032 While rst is held, PCSrcE and PCTargetE SHALL remain combinational functions of the inputs.

Verification
REQ-033 Reset: rst=1 for 2 cycles with random inputs -> all registered outputs are 0 after the first edge.
REQ-034 Add with immediate: RD1_E=5, Imm=7, ALUSrcE=1, ALUControlE=000, RD_E=3, RegWriteE=1 -> next cycle ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-035 Forwarding: cycle 1 produces ALUResultM=0x10; cycle 2 sets ForwardA_E=10, RD1_E=0, RD2_E=4, ALUControlE=001 -> ALUResultM=0xC.
- Same cycle 2 with ForwardA_E=01, ResultW=9 -> ALUResultM=5.
REQ-036 Branch: BranchE=1, RD1_E=RD2_E=0x20, ALUControlE=001, PCE=0x100, Imm=0x40 -> PCSrcE=1, PCTargetE=0x140.
- Same with RD2_E=0x21 -> PCSrcE=0.
REQ-037 SLT and store data: RD1_E=0xFFFFFFFF, RD2_E=1, ALUControlE=101 -> ALUResultM=1.
- Store with ALUSrcE=1, ForwardB_E=01, ResultW=0xAB -> WriteDataM=0xAB.
REQ-038 Stall and reset priority: StallM=1 for 3 cycles with changing inputs -> registered outputs are unchanged.
- Assert rst together with StallM=1 -> registered outputs are 0 on the next edge.
